app_block_ctrl: RTL and testbench

Initiator-side sequencer for the application codec interface.
- Accepts a multi-block command from the AHB slave register file.
- Gates each block on input-FIFO fill level and output-FIFO free space, then issues the codec start pulse with the block size.
- Monitors codec pushes and the done pulse, checks the word count, and enforces a per-block timeout.
- Reports progress, error code and a sticky interrupt back to the AHB slave.

---
 rtl/app_block_ctrl_if.sv | 33 +++
 rtl/app_block_ctrl.sv | 130 +++++++++++++
 tb/tb_app_block_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/app_block_ctrl_if.sv
// Command, FIFO-status, codec handshake and status signals between the block
// sequencer (slave) and its surroundings: AHB slave, FIFOs and codec (master).
interface app_block_ctrl_if #(
    parameter int LEVEL_W = 6
);
    logic               cmd_start;
    logic [4:0]         cmd_block_size;
    logic [7:0]         cmd_num_blocks;
    logic               cmd_abort;
    logic [LEVEL_W-1:0] in_fifo_level;
    logic [LEVEL_W-1:0] out_fifo_space;
    logic               app_start;
    logic [4:0]         block_size;
    logic               app_push;
    logic               app_done;
    logic               irq_clr;
    logic               busy;
    logic [7:0]         blocks_done;
    logic               irq;
    logic [1:0]         err_code;

    modport master (
        output cmd_start, cmd_block_size, cmd_num_blocks, cmd_abort,
        output in_fifo_level, out_fifo_space, app_push, app_done, irq_clr,
        input  app_start, block_size, busy, blocks_done, irq, err_code
    );

    modport slave (
        input  cmd_start, cmd_block_size, cmd_num_blocks, cmd_abort,
        input  in_fifo_level, out_fifo_space, app_push, app_done, irq_clr,
        output app_start, block_size, busy, blocks_done, irq, err_code
    );
endinterface

// File: rtl/app_block_ctrl.sv
// Initiator-side block sequencer for the codec: gates each block on FIFO
// fill/space, pulses start, checks push count and done, enforces a timeout.
module app_block_ctrl #(
    parameter int LEVEL_W = 6,
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic            clk,
    input  logic            hreset,
    app_block_ctrl_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_START, S_RUN, S_FIN} state_t;

    state_t            state_q, state_d;
    logic [4:0]        size_q, size_d;
    logic [7:0]        num_q, num_d;
    logic [7:0]        done_cnt_q, done_cnt_d;
    logic [4:0]        push_q, push_d;
    logic [TO_W-1:0]   timer_q, timer_d;
    logic [1:0]        err_q, err_d;
    logic              irq_q, irq_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              irq_set;
    logic [4:0]        push_now;
    logic              fifo_ready;

    // Push count including this cycle's strobe, saturating at 31
    assign push_now   = (bus.app_push && push_q != 5'd31) ? push_q + 5'd1 : push_q;
    assign fifo_ready = (bus.in_fifo_level  >= LEVEL_W'(size_q)) &&
                        (bus.out_fifo_space >= LEVEL_W'(size_q));

    always_ff @(posedge clk or posedge hreset) begin
        if (hreset) begin
            state_q    <= S_IDLE;
            size_q     <= '0;
            num_q      <= '0;
            done_cnt_q <= '0;
            push_q     <= '0;
            timer_q    <= '0;
            err_q      <= '0;
            irq_q      <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            num_q      <= num_d;
            done_cnt_q <= done_cnt_d;
            push_q     <= push_d;
            timer_q    <= timer_d;
            err_q      <= err_d;
            irq_q      <= irq_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        num_d      = num_q;
        done_cnt_d = done_cnt_q;
        push_d     = push_q;
        timer_d    = timer_q;
        err_d      = err_q;
        irq_set    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_start) begin
                    if (bus.cmd_block_size == 5'd0 || bus.cmd_num_blocks == 8'd0) begin
                        err_d   = 2'b01;
                        irq_set = 1'b1;
                    end else begin
                        size_d     = bus.cmd_block_size;
                        num_d      = bus.cmd_num_blocks;
                        done_cnt_d = 8'd0;
                        err_d      = 2'b00;
                        state_d    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus.cmd_abort)   state_d = S_IDLE;
                else if (fifo_ready) state_d = S_START;
            end
            S_START: begin
                push_d  = '0;
                timer_d = '0;
                state_d = bus.cmd_abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                push_d  = push_now;
                timer_d = timer_q + 1'b1;
                if (bus.cmd_abort) begin
                    state_d = S_IDLE;
                end else if (bus.app_done) begin
                    if (push_now != size_q) begin
                        err_d   = 2'b10;
                        state_d = S_FIN;
                    end else begin
                        done_cnt_d = done_cnt_q + 8'd1;
                        state_d    = (done_cnt_d == num_q) ? S_FIN : S_WAIT;
                    end
                end else if (timer_q == TO_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th RUN cycle; a done here would have won above
                    err_d   = 2'b11;
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                irq_set = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        start_d = (state_d == S_START);
        busy_d  = (state_d != S_IDLE);
        irq_d   = irq_set ? 1'b1 : (bus.irq_clr ? 1'b0 : irq_q);
    end

    assign bus.app_start   = start_q;
    assign bus.block_size  = size_q;
    assign bus.busy        = busy_q;
    assign bus.blocks_done = done_cnt_q;
    assign bus.irq         = irq_q;
    assign bus.err_code    = err_q;
endmodule

// File: tb/tb_app_block_ctrl.sv
// Directed bench for app_block_ctrl: inputs change and outputs are checked on
// the falling edge, one rising edge per tick.
module tb_app_block_ctrl;
    logic clk;
    logic hreset;
    int   total = 0;
    int   bad   = 0;

    app_block_ctrl_if #(.LEVEL_W(6)) bus ();

    app_block_ctrl #(.LEVEL_W(6), .TIMEOUT(1023), .TO_W(10)) dut (
        .clk    (clk),
        .hreset (hreset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [4:0] sz, input logic [7:0] nb);
        bus.cmd_start      = 1'b1;
        bus.cmd_block_size = sz;
        bus.cmd_num_blocks = nb;
        tick();
        bus.cmd_start = 1'b0;
    endtask

    // Returns on the falling edge of the START cycle, or flags a bound expiry
    task automatic wait_start(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (bus.app_start !== 1'b1 && n < 300);
        chk(tag, bus.app_start, 1);
    endtask

    // Codec model: n pushes starting in the first RUN cycle, done on the last
    task automatic codec(input int n);
        tick();
        for (int i = 0; i < n; i++) begin
            bus.app_push = 1'b1;
            bus.app_done = (i == n - 1);
            tick();
        end
        bus.app_push = 1'b0;
        bus.app_done = 1'b0;
    endtask

    task automatic clear_irq();
        bus.irq_clr = 1'b1;
        tick();
        bus.irq_clr = 1'b0;
    endtask

    initial begin
        bit seen;
        hreset             = 1'b1;
        bus.cmd_start      = 1'b0;
        bus.cmd_block_size = '0;
        bus.cmd_num_blocks = '0;
        bus.cmd_abort      = 1'b0;
        bus.in_fifo_level  = 6'd8;
        bus.out_fifo_space = 6'd8;
        bus.app_push       = 1'b0;
        bus.app_done       = 1'b0;
        bus.irq_clr        = 1'b0;
        repeat (3) tick();
        hreset = 1'b0;
        tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_irq", bus.irq, 0);
        chk("rst_err", bus.err_code, 0);
        chk("rst_bdone", bus.blocks_done, 0);
        chk("rst_start", bus.app_start, 0);
        chk("rst_bsize", bus.block_size, 0);
        $display("reset checked");

        // Single block, size 4: start at cycle 2, irq two cycles after done
        issue(5'd4, 8'd1);
        chk("t1_busy_c1", bus.busy, 1);
        chk("t1_nostart_c1", bus.app_start, 0);
        tick();
        chk("t1_start_c2", bus.app_start, 1);
        chk("t1_bsize", bus.block_size, 4);
        codec(4);
        chk("t1_fin_irq", bus.irq, 0);
        chk("t1_fin_busy", bus.busy, 1);
        chk("t1_bdone", bus.blocks_done, 1);
        tick();
        chk("t1_irq", bus.irq, 1);
        chk("t1_busy", bus.busy, 0);
        chk("t1_err", bus.err_code, 0);
        $display("txn single block: bdone=%0d err=%0d irq=%0d", bus.blocks_done, bus.err_code, bus.irq);
        clear_irq();
        chk("t1_irqclr", bus.irq, 0);

        // Three blocks of 8, input FIFO short for 20 cycles
        bus.in_fifo_level = 6'd5;
        issue(5'd8, 8'd3);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.app_start) seen = 1'b1;
        end
        chk("t2_gated", seen, 0);
        chk("t2_busy_wait", bus.busy, 1);
        bus.in_fifo_level = 6'd8;
        for (int b = 0; b < 3; b++) begin
            wait_start("t2_start");
            codec(8);
        end
        tick();
        chk("t2_irq", bus.irq, 1);
        chk("t2_bdone", bus.blocks_done, 3);
        chk("t2_err", bus.err_code, 0);
        chk("t2_busy", bus.busy, 0);
        $display("txn three blocks: bdone=%0d err=%0d", bus.blocks_done, bus.err_code);
        clear_irq();

        // Bad commands
        issue(5'd0, 8'd5);
        chk("t3_busy_sz0", bus.busy, 0);
        chk("t3_err_sz0", bus.err_code, 1);
        chk("t3_irq_sz0", bus.irq, 1);
        clear_irq();
        chk("t3_irqclr", bus.irq, 0);
        issue(5'd4, 8'd0);
        chk("t3_busy_nb0", bus.busy, 0);
        chk("t3_err_nb0", bus.err_code, 1);
        chk("t3_irq_nb0", bus.irq, 1);
        clear_irq();
        chk("t3_irqclr2", bus.irq, 0);
        $display("txn bad commands: err=%0d", bus.err_code);

        // Count mismatch: 3 pushes for a 4-word block
        issue(5'd4, 8'd2);
        wait_start("t4_start");
        codec(3);
        chk("t4_err", bus.err_code, 2);
        chk("t4_bdone", bus.blocks_done, 0);
        tick();
        chk("t4_irq", bus.irq, 1);
        chk("t4_busy", bus.busy, 0);
        $display("txn mismatch: err=%0d bdone=%0d", bus.err_code, bus.blocks_done);
        clear_irq();

        // Timeout: no done for 1023 RUN cycles
        issue(5'd4, 8'd1);
        wait_start("t5_start");
        repeat (1023) tick();
        chk("t5_run_last", bus.busy, 1);
        chk("t5_err_pre", bus.err_code, 0);
        tick();
        chk("t5_err", bus.err_code, 3);
        tick();
        chk("t5_irq", bus.irq, 1);
        chk("t5_busy", bus.busy, 0);
        $display("txn timeout: err=%0d", bus.err_code);
        clear_irq();

        // Done exactly on the timeout cycle wins
        issue(5'd4, 8'd1);
        wait_start("t5b_start");
        tick();
        bus.app_push = 1'b1;
        repeat (3) tick();
        bus.app_push = 1'b0;
        repeat (1019) tick();
        bus.app_push = 1'b1;
        bus.app_done = 1'b1;
        tick();
        bus.app_push = 1'b0;
        bus.app_done = 1'b0;
        chk("t5b_err", bus.err_code, 0);
        chk("t5b_bdone", bus.blocks_done, 1);
        tick();
        chk("t5b_irq", bus.irq, 1);
        $display("txn done at timeout: err=%0d bdone=%0d", bus.err_code, bus.blocks_done);
        clear_irq();

        // Abort mid-RUN of block 2 of 4
        issue(5'd2, 8'd4);
        wait_start("t6_start1");
        codec(2);
        wait_start("t6_start2");
        tick();
        bus.app_push = 1'b1;
        tick();
        bus.app_push  = 1'b0;
        bus.cmd_abort = 1'b1;
        tick();
        bus.cmd_abort = 1'b0;
        chk("t6_busy", bus.busy, 0);
        chk("t6_bdone", bus.blocks_done, 1);
        chk("t6_irq", bus.irq, 0);
        chk("t6_err", bus.err_code, 0);
        repeat (3) tick();
        chk("t6_irq_later", bus.irq, 0);
        $display("txn abort: bdone=%0d irq=%0d", bus.blocks_done, bus.irq);

        // New command accepted; a bad cmd_start while busy is ignored
        bus.cmd_start      = 1'b1;
        bus.cmd_block_size = 5'd3;
        bus.cmd_num_blocks = 8'd1;
        tick();
        chk("t6_busy2", bus.busy, 1);
        bus.cmd_block_size = 5'd0;
        bus.cmd_num_blocks = 8'd0;
        tick();
        bus.cmd_start = 1'b0;
        chk("t6_start3", bus.app_start, 1);
        chk("t6_err_ign", bus.err_code, 0);
        chk("t6_bsize_ign", bus.block_size, 3);
        codec(3);
        tick();
        chk("t6_bdone2", bus.blocks_done, 1);
        chk("t6_irq2", bus.irq, 1);
        $display("txn restart: bdone=%0d err=%0d irq=%0d", bus.blocks_done, bus.err_code, bus.irq);

        // Reset during RUN returns to reset values immediately
        issue(5'd2, 8'd1);
        wait_start("t7_start");
        tick();
        hreset = 1'b1;
        #1;
        chk("t7_busy", bus.busy, 0);
        chk("t7_irq", bus.irq, 0);
        chk("t7_bsize", bus.block_size, 0);
        tick();
        hreset = 1'b0;
        tick();
        chk("t7_irq_after", bus.irq, 0);
        $display("txn reset mid-run: busy=%0d irq=%0d", bus.busy, bus.irq);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
